// File: rtl/icp_pkg.sv
// Shared constants for the intcode processor and its memory: op codes,
// memory FSM states and default bus widths.
package icp_pkg;

    localparam int unsigned ICP_ADDR_W = 13;
    localparam int unsigned ICP_DATA_W = 64;
    localparam int unsigned ICP_NPORTS = 4;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_READ  = 2'd1;
    localparam logic [1:0] MEM_OP_WRITE = 2'd2;

    typedef enum logic [1:0] {
        S_MEM_CLEAR = 2'd0,
        S_MEM_LOAD  = 2'd1,
        S_MEM_RUN   = 2'd2
    } mem_state_e;

    // Index width needed to address a DEPTH-entry array (at least 1 bit).
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/icp_mem_array.sv
// Word storage with combinational read ports, one host read port and
// prioritised writes (clear, host, port 0..3; the later assignment wins).
module icp_mem_array
    import icp_pkg::*;
#(
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned ADDR_W = ICP_ADDR_W,
    parameter int unsigned DATA_W = ICP_DATA_W,
    parameter int unsigned NPORTS = ICP_NPORTS
) (
    input  logic              i_clk,
    input  logic              i_clr_we,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_port_we    [NPORTS-1:0],
    input  logic [ADDR_W-1:0] i_port_addr  [NPORTS-1:0],
    input  logic [DATA_W-1:0] i_port_wdata [NPORTS-1:0],
    output logic [DATA_W-1:0] o_port_rdata [NPORTS-1:0]
);

    localparam int unsigned     IDX_W = idx_w(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_clr_we && in_range(i_clr_addr))
            r_mem[i_clr_addr[IDX_W-1:0]] <= '0;
        if (i_host_we && in_range(i_host_addr))
            r_mem[i_host_addr[IDX_W-1:0]] <= i_host_wdata;
        for (int p = 0; p < NPORTS; p++) begin
            if (i_port_we[p] && in_range(i_port_addr[p]))
                r_mem[i_port_addr[p][IDX_W-1:0]] <= i_port_wdata[p];
        end
    end

    // Out-of-range reads return zero.
    always_comb begin
        o_host_rdata = in_range(i_host_addr) ? r_mem[i_host_addr[IDX_W-1:0]] : '0;
        for (int p = 0; p < NPORTS; p++) begin
            o_port_rdata[p] = in_range(i_port_addr[p]) ? r_mem[i_port_addr[p][IDX_W-1:0]] : '0;
        end
    end

endmodule

// File: rtl/icp_mem.sv
// Four-port intcode memory: clear -> host load -> run sequencing.
// Optional sticky protocol-error detection under macro ICP_MEM_ERR_EN.
module icp_mem
    import icp_pkg::*;
#(
    parameter int unsigned DEPTH  = 8192,
    parameter int unsigned ADDR_W = ICP_ADDR_W,
    parameter int unsigned DATA_W = ICP_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_op   [3:0],
    input  logic [ADDR_W-1:0] i_addr [3:0],
    input  logic [DATA_W-1:0] i_data [3:0],
    output logic [DATA_W-1:0] o_data [3:0],
    input  logic              i_load_we,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    output logic [DATA_W-1:0] o_load_rdata,
    input  logic              i_start,
    output logic              o_loading,
    output logic              o_ready,
    output logic              o_err
);

    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

    mem_state_e        r_state;
    mem_state_e        w_next_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_host_we;
    logic [DATA_W-1:0] w_host_rdata;
    logic              w_port_we  [3:0];
    logic [DATA_W-1:0] w_rd_data  [3:0];

    assign w_clr_addr = ADDR_W'(r_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_MEM_CLEAR;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                       r_cnt <= '0;
        else if (r_state == S_MEM_CLEAR) r_cnt <= r_cnt + IDX_W'(1);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_MEM_CLEAR: if (r_cnt == CNT_LAST) w_next_state = S_MEM_LOAD;
            S_MEM_LOAD:  if (i_start)           w_next_state = S_MEM_RUN;
            S_MEM_RUN:   w_next_state = S_MEM_RUN;
            default:     w_next_state = S_MEM_CLEAR;
        endcase
    end

    // Gate array writes and read data by phase; op 3 falls through as NONE.
    always_comb begin
        o_loading    = 1'b0;
        o_ready      = 1'b0;
        w_clr_we     = 1'b0;
        w_host_we    = 1'b0;
        o_load_rdata = '0;
        for (int p = 0; p < 4; p++) begin
            w_port_we[p] = 1'b0;
            o_data[p]    = '0;
        end
        case (r_state)
            S_MEM_CLEAR: w_clr_we = 1'b1;
            S_MEM_LOAD: begin
                o_loading    = 1'b1;
                w_host_we    = i_load_we;
                o_load_rdata = w_host_rdata;
            end
            S_MEM_RUN: begin
                o_ready      = 1'b1;
                o_load_rdata = w_host_rdata;
                for (int p = 0; p < 4; p++) begin
                    w_port_we[p] = (i_op[p] == MEM_OP_WRITE);
                    o_data[p]    = (i_op[p] == MEM_OP_READ) ? w_rd_data[p] : '0;
                end
            end
            default: ;
        endcase
    end

    icp_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NPORTS (4)
    ) u_array (
        .i_clk        (i_clk),
        .i_clr_we     (w_clr_we),
        .i_clr_addr   (w_clr_addr),
        .i_host_we    (w_host_we),
        .i_host_addr  (i_load_addr),
        .i_host_wdata (i_load_data),
        .o_host_rdata (w_host_rdata),
        .i_port_we    (w_port_we),
        .i_port_addr  (i_addr),
        .i_port_wdata (i_data),
        .o_port_rdata (w_rd_data)
    );

`ifdef ICP_MEM_ERR_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic r_err;
    logic w_err_hit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    // Illegal op, out-of-range access, or colliding writes in one cycle.
    always_comb begin
        w_err_hit = 1'b0;
        if (r_state == S_MEM_RUN) begin
            for (int p = 0; p < 4; p++) begin
                if (i_op[p] == 2'd3)
                    w_err_hit = 1'b1;
                if ((i_op[p] == MEM_OP_READ || i_op[p] == MEM_OP_WRITE) && !in_range(i_addr[p]))
                    w_err_hit = 1'b1;
                for (int q = p + 1; q < 4; q++) begin
                    if (i_op[p] == MEM_OP_WRITE && i_op[q] == MEM_OP_WRITE && i_addr[p] == i_addr[q])
                        w_err_hit = 1'b1;
                end
            end
        end else if (r_state == S_MEM_LOAD) begin
            if (i_load_we && !in_range(i_load_addr))
                w_err_hit = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          r_err <= 1'b0;
        else if (w_err_hit) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_icp_mem.sv
// Self-checking bench for icp_mem (DEPTH=16) against a word-array reference
// model; honours ICP_MEM_ERR_EN for the expected o_err behaviour.
module tb_icp_mem;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 64;
`ifdef ICP_MEM_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_op   [3:0];
    logic [AW-1:0] i_addr [3:0];
    logic [DW-1:0] i_data [3:0];
    logic [DW-1:0] o_data [3:0];
    logic          i_load_we;
    logic [AW-1:0] i_load_addr;
    logic [DW-1:0] i_load_data;
    logic [DW-1:0] o_load_rdata;
    logic          i_start;
    logic          o_loading;
    logic          o_ready;
    logic          o_err;

    always #5 clk = ~clk;

    icp_mem #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_op         (i_op),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .o_data       (o_data),
        .i_load_we    (i_load_we),
        .i_load_addr  (i_load_addr),
        .i_load_data  (i_load_data),
        .o_load_rdata (o_load_rdata),
        .i_start      (i_start),
        .o_loading    (o_loading),
        .o_ready      (o_ready),
        .o_err        (o_err)
    );

    // Reference model: phase 0 clearing, 1 loading, 2 running.
    logic [DW-1:0] m [DEPTH];
    int            ph;
    int            ccnt;
    bit            merr;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int a);
        return (a < int'(DEPTH)) ? m[a] : '0;
    endfunction

    task automatic check_all();
        for (int p = 0; p < 4; p++)
            chk($sformatf("o_data[%0d]", p), o_data[p],
                (ph == 2 && i_op[p] == 2'd1) ? rd(int'(i_addr[p])) : 64'd0);
        chk("o_load_rdata", o_load_rdata, (ph != 0) ? rd(int'(i_load_addr)) : 64'd0);
        chk("o_loading", 64'(o_loading), 64'(ph == 1));
        chk("o_ready", 64'(o_ready), 64'(ph == 2));
        chk("o_err", 64'(o_err), 64'(ERR_BUILD & merr));
    endtask

    task automatic model_edge();
        case (ph)
            0: begin
                m[ccnt] = '0;
                ccnt++;
                if (ccnt == int'(DEPTH)) ph = 1;
            end
            1: begin
                if (i_load_we) begin
                    if (int'(i_load_addr) < int'(DEPTH)) m[int'(i_load_addr)] = i_load_data;
                    else merr = 1'b1;
                end
                if (i_start) ph = 2;
            end
            default: begin
                for (int p = 0; p < 4; p++) begin
                    if (i_op[p] == 2'd3) merr = 1'b1;
                    if ((i_op[p] == 2'd1 || i_op[p] == 2'd2) && int'(i_addr[p]) >= int'(DEPTH)) merr = 1'b1;
                    for (int q = 0; q < p; q++)
                        if (i_op[p] == 2'd2 && i_op[q] == 2'd2 && i_addr[p] == i_addr[q]) merr = 1'b1;
                end
                for (int p = 0; p < 4; p++)
                    if (i_op[p] == 2'd2 && int'(i_addr[p]) < int'(DEPTH)) m[int'(i_addr[p])] = i_data[p];
            end
        endcase
    endtask

    task automatic cyc();
        #1;
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 4; p++) begin
            i_op[p]   = 2'd0;
            i_addr[p] = '0;
            i_data[p] = '0;
        end
        i_load_we = 1'b0;
        i_start   = 1'b0;
    endtask

    task automatic model_reset();
        ph   = 0;
        ccnt = 0;
        merr = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
    endtask

    task automatic do_reset_and_clear();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int i = 0; i < int'(DEPTH); i++) cyc();
    endtask

    initial begin
        rst         = 1'b1;
        i_load_addr = '0;
        i_load_data = '0;
        idle();

        // Clear phase: not loading/ready for DEPTH edges, then loading.
        do_reset_and_clear();
        chk("loading_after_clear", 64'(o_loading), 64'd1);
        chk("ready_after_clear", 64'(o_ready), 64'd0);
        i_load_addr = AW'(5);
        #1;
        chk("clear_addr5", o_load_rdata, 64'd0);

        // Load phase: port traffic is ignored.
        i_load_we   = 1'b1;
        i_load_addr = AW'(3);
        i_load_data = 64'h1234;
        i_op[0] = 2'd2; i_addr[0] = AW'(5); i_data[0] = 64'd99;
        i_op[2] = 2'd1; i_addr[2] = AW'(3);
        cyc();
        idle();
        i_load_we   = 1'b1;
        i_load_addr = AW'(4);
        i_load_data = 64'd7;
        i_start     = 1'b1;
        cyc();
        idle();
        chk("ready_after_start", 64'(o_ready), 64'd1);

        i_op[2] = 2'd1; i_addr[2] = AW'(3);
        i_addr[1] = AW'(3);
        i_load_addr = AW'(5);
        #1;
        chk("p2_read_addr3", o_data[2], 64'h1234);
        chk("p1_none_reads0", o_data[1], 64'd0);
        chk("load_port_write_ignored", o_load_rdata, 64'd0);
        i_load_addr = AW'(4);
        #1;
        chk("host_dump_addr4", o_load_rdata, 64'd7);
        cyc();

        // Write then read back; same-cycle read sees the old value.
        idle();
        i_op[0] = 2'd2; i_addr[0] = AW'(9); i_data[0] = 64'd42;
        i_op[1] = 2'd1; i_addr[1] = AW'(9);
        #1;
        chk("read_in_write_cycle", o_data[1], 64'd0);
        cyc();
        idle();
        i_op[0] = 2'd1; i_addr[0] = AW'(9);
        #1;
        chk("read_after_write", o_data[0], 64'd42);
        cyc();

        // Random traffic without protocol errors: each port writes only its quarter.
        for (int c = 0; c < 120; c++) begin
            for (int p = 0; p < 4; p++) begin
                i_op[p] = 2'($urandom_range(0, 2));
                if (i_op[p] == 2'd2) i_addr[p] = AW'(p * 4 + $urandom_range(0, 3));
                else                 i_addr[p] = AW'($urandom_range(0, DEPTH - 1));
                i_data[p] = {$urandom, $urandom};
            end
            i_load_we   = 1'($urandom_range(0, 1));
            i_load_addr = AW'($urandom_range(0, DEPTH - 1));
            i_load_data = {$urandom, $urandom};
            i_start     = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("no_err_clean_traffic", 64'(o_err), 64'd0);

        // Same-address write conflict: highest port wins.
        idle();
        i_op[1] = 2'd2; i_addr[1] = AW'(6); i_data[1] = 64'd11;
        i_op[3] = 2'd2; i_addr[3] = AW'(6); i_data[3] = 64'd22;
        cyc();
        idle();
        i_op[0] = 2'd1; i_addr[0] = AW'(6);
        #1;
        chk("conflict_p3_wins", o_data[0], 64'd22);
        chk("err_on_conflict", 64'(o_err), 64'(ERR_BUILD));
        cyc();
        cyc();
        chk("err_sticky", 64'(o_err), 64'(ERR_BUILD));

        // Fully random traffic including illegal ops and out-of-range addresses.
        for (int c = 0; c < 200; c++) begin
            for (int p = 0; p < 4; p++) begin
                i_op[p]   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                i_addr[p] = AW'($urandom_range(0, DEPTH + 3));
                i_data[p] = {$urandom, $urandom};
            end
            i_load_addr = AW'($urandom_range(0, DEPTH + 3));
            cyc();
        end

        // Asynchronous reset mid-run wipes the array.
        idle();
        i_op[0] = 2'd2; i_addr[0] = AW'(2); i_data[0] = 64'd5;
        cyc();
        idle();
        i_op[0] = 2'd1; i_addr[0] = AW'(2);
        #1;
        chk("pre_reset_read2", o_data[0], 64'd5);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("ready_drops_on_reset", 64'(o_ready), 64'd0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int i = 0; i < int'(DEPTH); i++) cyc();
        i_load_addr = AW'(2);
        #1;
        chk("addr2_cleared", o_load_rdata, 64'd0);

        // Out-of-range read.
        i_start = 1'b1;
        cyc();
        idle();
        i_op[0] = 2'd1; i_addr[0] = AW'(DEPTH + 1);
        #1;
        chk("oor_read_zero", o_data[0], 64'd0);
        cyc();
        chk("err_oor_read", 64'(o_err), 64'(ERR_BUILD));

        // Illegal op alone from a fresh reset.
        do_reset_and_clear();
        chk("err_clear_after_reset", 64'(o_err), 64'd0);
        i_start = 1'b1;
        cyc();
        idle();
        i_op[2] = 2'd3; i_addr[2] = AW'(1);
        #1;
        chk("op3_reads_zero", o_data[2], 64'd0);
        cyc();
        idle();
        chk("err_op3", 64'(o_err), 64'(ERR_BUILD));
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
